// File: rtl/neo_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// neo_pkg : shared WS2812 timing constants, pixel word and decoder states
// Revision: 1.0
// ------------------------------------------------------------------
package neo_pkg;

  localparam int T0H          = 18;
  localparam int T1H          = 40;
  localparam int T0L          = 40;
  localparam int T1L          = 22;
  localparam int RESET_CYCLES = 2500;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } grb_t;

  typedef enum logic [1:0] {
    ARM  = 2'd0,
    IDLE = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } dec_state_t;

endpackage
`default_nettype wire

// File: rtl/neo_pixel_decoder_if.sv
`default_nettype none
// ------------------------------------------------------------------
// neo_pixel_decoder_if : serial input and decoded pixel/frame outputs
// Revision: 1.0
// ------------------------------------------------------------------
interface neo_pixel_decoder_if;
  logic        neo_in;
  logic        pixel_valid;
  logic [23:0] pixel_data;
  logic [2:0]  pixel_index;
  logic        frame_done;
  logic [3:0]  pixel_count;
  logic        proto_error;
  logic        error_seen;

  modport master (
    input  neo_in,
    output pixel_valid, pixel_data, pixel_index, frame_done,
    output pixel_count, proto_error, error_seen
  );

  modport slave (
    output neo_in,
    input  pixel_valid, pixel_data, pixel_index, frame_done,
    input  pixel_count, proto_error, error_seen
  );
endinterface
`default_nettype wire

// File: rtl/neo_pixel_decoder_sync.sv
`default_nettype none
// ------------------------------------------------------------------
// neo_sync : two-flop synchronizer for the asynchronous serial line
// Revision: 1.0
// ------------------------------------------------------------------
module neo_sync (
  input  logic clock,
  input  logic reset,
  input  logic din_i,
  output logic dout_o
);
  logic [1:0] sync_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], din_i};
  end

  assign dout_o = sync_q[1];
endmodule
`default_nettype wire

// File: rtl/neo_pixel_decoder.sv
`default_nettype none
// ------------------------------------------------------------------
// neo_pixel_decoder : WS2812 NRZ receiver, high-time bit decode, GRB words
// Revision: 1.0
// ------------------------------------------------------------------
module neo_pixel_decoder
  import neo_pkg::*;
#(
  parameter int NUM_PIXELS   = 5,
  parameter int BIT_THRESH   = 29,
  parameter int MIN_HIGH     = 8,
  parameter int MAX_HIGH     = 60,
  parameter int MIN_LOW      = 8,
  parameter int RESET_CYCLES = neo_pkg::RESET_CYCLES
) (
  input  logic                 clock,
  input  logic                 reset,
  neo_pixel_decoder_if.master  bus
);
  localparam logic [11:0] CNT_SAT  = 12'(RESET_CYCLES);
  localparam logic [11:0] CNT_THR  = 12'(BIT_THRESH);
  localparam logic [11:0] CNT_MINH = 12'(MIN_HIGH);
  localparam logic [11:0] CNT_MAXH = 12'(MAX_HIGH);
  localparam logic [11:0] CNT_MINL = 12'(MIN_LOW);
  localparam logic [3:0]  PIX_LIM  = 4'(NUM_PIXELS);

  logic        s, s_prev_q, rise, fall, err;
  logic [23:0] word;
  dec_state_t  state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [4:0]  bitcnt_q, bitcnt_d;
  logic [3:0]  pixcnt_q, pixcnt_d;
  // Only 23 bits are kept: the 24th bit goes straight into the presented word.
  logic [22:0] shreg_q, shreg_d;
  logic        pixel_valid_q, pixel_valid_d;
  grb_t        pixel_data_q, pixel_data_d;
  logic [2:0]  pixel_index_q, pixel_index_d;
  logic        frame_done_q, frame_done_d;
  logic [3:0]  pixel_count_q, pixel_count_d;
  logic        proto_error_q, proto_error_d;
  logic        error_seen_q, error_seen_d;

  neo_sync u_sync (
    .clock  (clock),
    .reset  (reset),
    .din_i  (bus.neo_in),
    .dout_o (s)
  );

  assign rise = s & ~s_prev_q;
  assign fall = ~s & s_prev_q;
  assign word = {shreg_q, (cnt_q >= CNT_THR)};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s_prev_q      <= 1'b0;
      state_q       <= ARM;
      cnt_q         <= '0;
      bitcnt_q      <= '0;
      pixcnt_q      <= '0;
      shreg_q       <= '0;
      pixel_valid_q <= 1'b0;
      pixel_data_q  <= '0;
      pixel_index_q <= '0;
      frame_done_q  <= 1'b0;
      pixel_count_q <= '0;
      proto_error_q <= 1'b0;
      error_seen_q  <= 1'b0;
    end else begin
      s_prev_q      <= s;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bitcnt_q      <= bitcnt_d;
      pixcnt_q      <= pixcnt_d;
      shreg_q       <= shreg_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_data_q  <= pixel_data_d;
      pixel_index_q <= pixel_index_d;
      frame_done_q  <= frame_done_d;
      pixel_count_q <= pixel_count_d;
      proto_error_q <= proto_error_d;
      error_seen_q  <= error_seen_d;
    end
  end

  always_comb begin
    cnt_d         = cnt_q;
    state_d       = state_q;
    bitcnt_d      = bitcnt_q;
    pixcnt_d      = pixcnt_q;
    shreg_d       = shreg_q;
    pixel_valid_d = 1'b0;
    pixel_data_d  = pixel_data_q;
    pixel_index_d = pixel_index_q;
    frame_done_d  = 1'b0;
    pixel_count_d = pixel_count_q;
    proto_error_d = 1'b0;
    error_seen_d  = error_seen_q;
    err           = 1'b0;

    if (rise || fall)        cnt_d = 12'd1;
    else if (cnt_q < CNT_SAT) cnt_d = cnt_q + 12'd1;

    unique case (state_q)
      ARM: begin
        if (!s && cnt_q == CNT_SAT) state_d = IDLE;
      end
      IDLE: begin
        if (rise) begin
          state_d  = HIGH;
          bitcnt_d = '0;
          pixcnt_d = '0;
          shreg_d  = '0;
        end
      end
      HIGH: begin
        err = (cnt_q > CNT_MAXH) || (fall && cnt_q < CNT_MINH);
        if (fall && !err) begin
          shreg_d = word[22:0];
          if (bitcnt_q == 5'd23) begin
            bitcnt_d = '0;
            if (pixcnt_q < PIX_LIM) begin
              pixel_valid_d = 1'b1;
              pixel_data_d  = grb_t'(word);
              pixel_index_d = pixcnt_q[2:0];
            end
            if (pixcnt_q != 4'hF) pixcnt_d = pixcnt_q + 4'd1;
          end else begin
            bitcnt_d = bitcnt_q + 5'd1;
          end
          state_d = LOW;
        end
      end
      LOW: begin
        // A rise landing exactly on the latch count still ends the frame, then starts the next.
        if (cnt_q == CNT_SAT) begin
          if (bitcnt_q != '0) begin
            err = 1'b1;
          end else begin
            frame_done_d  = 1'b1;
            pixel_count_d = pixcnt_q;
            state_d       = rise ? HIGH : IDLE;
            pixcnt_d      = '0;
            shreg_d       = '0;
          end
        end else if (rise) begin
          if (cnt_q < CNT_MINL) err = 1'b1;
          else                  state_d = HIGH;
        end
      end
      default: state_d = ARM;
    endcase

    if (err) begin
      proto_error_d = 1'b1;
      error_seen_d  = 1'b1;
      state_d       = ARM;
      bitcnt_d      = '0;
      pixcnt_d      = '0;
      shreg_d       = '0;
    end
  end

  assign bus.pixel_valid = pixel_valid_q;
  assign bus.pixel_data  = pixel_data_q;
  assign bus.pixel_index = pixel_index_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.pixel_count = pixel_count_q;
  assign bus.proto_error = proto_error_q;
  assign bus.error_seen  = error_seen_q;
endmodule
`default_nettype wire

// File: tb/tb_neo_pixel_decoder.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_neo_pixel_decoder : randomized WS2812 frames against a pulse-level model
// Revision: 1.0
// ------------------------------------------------------------------
module tb_neo_pixel_decoder;
  import neo_pkg::*;

  localparam int NPIX = 5;
  localparam int THR  = 29;
  localparam int MINH = 8;
  localparam int MAXH = 60;
  localparam int MINL = 8;
  localparam int RC   = 2500;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #10 clock = ~clock;

  neo_pixel_decoder_if bus();

  neo_pixel_decoder #(
    .NUM_PIXELS(NPIX), .BIT_THRESH(THR), .MIN_HIGH(MINH),
    .MAX_HIGH(MAXH), .MIN_LOW(MINL), .RESET_CYCLES(RC)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef enum int {EV_PIX, EV_FRAME, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [23:0] data;
    int          idx;
  } ev_t;

  ev_t expq[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  // Reference model state: what a WS2812 receiver should have seen so far.
  bit          armed = 1'b0;
  bit          m_active = 1'b0;
  bit          m_bits_q[$];
  int          m_pix = 0;
  int          m_prev_low = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(ev_kind_t k, logic [23:0] d, int i);
    ev_t e;
    e.kind = k; e.data = d; e.idx = i;
    expq.push_back(e);
  endtask

  task automatic model_abort();
    push(EV_ERR, 24'h0, 0);
    armed    = 1'b0;
    m_active = 1'b0;
    m_bits_q.delete();
    m_pix    = 0;
  endtask

  function automatic logic [23:0] pack_bits();
    logic [23:0] w = '0;
    for (int i = 0; i < 24; i++) w[23 - i] = m_bits_q[i];
    return w;
  endfunction

  task automatic hold(logic v, int n);
    bus.neo_in = v;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse(int h, int l);
    if (armed) begin
      if (m_active && m_prev_low < MINL) begin
        model_abort();
      end else if (h < MINH || h > MAXH) begin
        model_abort();
      end else begin
        m_active = 1'b1;
        m_bits_q.push_back(h >= THR);
        if (m_bits_q.size() == 24) begin
          if (m_pix < NPIX) push(EV_PIX, pack_bits(), m_pix);
          m_pix = (m_pix + 1 > 15) ? 15 : m_pix + 1;
          m_bits_q.delete();
        end
        m_prev_low = l;
      end
    end
    hold(1'b1, h);
    hold(1'b0, l);
  endtask

  task automatic latch();
    if (armed && m_active) begin
      if (m_bits_q.size() != 0) push(EV_ERR, 24'h0, 0);
      else                      push(EV_FRAME, 24'h0, m_pix);
    end
    hold(1'b0, RC + 20);
    armed    = 1'b1;
    m_active = 1'b0;
    m_bits_q.delete();
    m_pix    = 0;
  endtask

  task automatic rand_bit(bit b);
    int h;
    h = b ? $urandom_range(MAXH, THR) : $urandom_range(THR - 1, MINH);
    pulse(h, $urandom_range(60, MINL));
  endtask

  task automatic send_word(logic [23:0] w, bit nominal);
    for (int i = 23; i >= 0; i--) begin
      if (nominal) begin
        if (w[i]) pulse(T1H, T1L);
        else      pulse(T0H, T0L);
      end else begin
        rand_bit(w[i]);
      end
    end
  endtask

  task automatic check_zero_outputs(string tag);
    check({tag, "_pixel_valid"}, bus.pixel_valid, 0);
    check({tag, "_pixel_data"},  bus.pixel_data,  0);
    check({tag, "_pixel_index"}, bus.pixel_index, 0);
    check({tag, "_frame_done"},  bus.frame_done,  0);
    check({tag, "_pixel_count"}, bus.pixel_count, 0);
    check({tag, "_proto_error"}, bus.proto_error, 0);
    check({tag, "_error_seen"},  bus.error_seen,  0);
  endtask

  // Monitor: every output pulse must match the next expected event in order.
  always @(negedge clock) begin
    if (!reset && (bus.pixel_valid || bus.frame_done || bus.proto_error)) begin
      if (expq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_event: got pv=%0b fd=%0b pe=%0b data=%06h, expected no event (t=%0t)",
                 bus.pixel_valid, bus.frame_done, bus.proto_error, bus.pixel_data, $time);
      end else begin
        ev_t e;
        logic [2:0] code;
        e = expq.pop_front();
        code = (e.kind == EV_PIX) ? 3'b100 : (e.kind == EV_FRAME) ? 3'b010 : 3'b001;
        check("event_kind", {bus.pixel_valid, bus.frame_done, bus.proto_error}, code);
        if (e.kind == EV_PIX) begin
          check("pixel_data",  bus.pixel_data,  e.data);
          check("pixel_index", bus.pixel_index, e.idx);
        end else if (e.kind == EV_FRAME) begin
          check("pixel_count", bus.pixel_count, e.idx);
        end else begin
          check("error_seen_on_err", bus.error_seen, 1);
        end
      end
    end
  end

  initial begin
    bus.neo_in = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check_zero_outputs("reset");
    reset = 1'b0;

    // Nominal frame of five known pixels.
    latch();
    send_word(24'h00FF00, 1'b1);
    send_word(24'hFF0000, 1'b1);
    send_word(24'h0000FF, 1'b1);
    send_word(24'hA5A5A5, 1'b1);
    send_word(24'h123456, 1'b1);
    latch();
    check("frame1_pixel_count", bus.pixel_count, 5);
    check("frame1_no_error", bus.error_seen, 0);

    // Live line across reset release: nothing decodes until a full latch gap.
    reset = 1'b1;
    armed = 1'b0;
    for (int i = 0; i < 30; i++) rand_bit($urandom_range(1, 0));
    reset = 1'b0;
    for (int i = 0; i < 40; i++) rand_bit($urandom_range(1, 0));
    latch();
    send_word($urandom, 1'b0);
    send_word($urandom, 1'b0);
    latch();

    // Threshold sweep: 28/29/60 close a word as bits 0,1,1; 61 is an error.
    for (int i = 0; i < 21; i++) rand_bit($urandom_range(1, 0));
    pulse(28, 30);
    pulse(29, 30);
    pulse(60, 30);
    pulse(61, 30);
    check("sweep_error_seen", bus.error_seen, 1);
    latch();

    // 30 bits: one pixel, then a partial word at the latch.
    send_word($urandom, 1'b0);
    for (int i = 0; i < 6; i++) rand_bit($urandom_range(1, 0));
    latch();

    // Seven pixels: five reported, count of seven.
    for (int i = 0; i < 7; i++) send_word($urandom, 1'b0);
    latch();

    // Short high glitch between bits.
    for (int i = 0; i < 5; i++) rand_bit($urandom_range(1, 0));
    pulse(5, 30);
    for (int i = 0; i < 3; i++) rand_bit($urandom_range(1, 0));
    latch();

    // Short low gap between bits.
    for (int i = 0; i < 3; i++) rand_bit($urandom_range(1, 0));
    pulse(20, 5);
    pulse(40, 20);
    latch();

    // Reset in the middle of a pixel.
    for (int i = 0; i < 10; i++) rand_bit($urandom_range(1, 0));
    bus.neo_in = 1'b1;
    reset = 1'b1;
    #1;
    check_zero_outputs("midreset");
    armed    = 1'b0;
    m_active = 1'b0;
    m_bits_q.delete();
    m_pix    = 0;
    hold(1'b1, 7);
    hold(1'b0, 3);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) rand_bit($urandom_range(1, 0));
    latch();
    send_word($urandom, 1'b0);
    latch();

    // A couple of random short frames.
    for (int f = 0; f < 2; f++) begin
      int nw;
      nw = $urandom_range(2, 1);
      for (int i = 0; i < nw; i++) send_word($urandom, 1'b0);
      latch();
    end

    repeat (10) @(posedge clock);
    #1;
    check("queue_drained", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
